// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM responder.
package arm_mem_pkg;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} mem_state_t;

  localparam int unsigned ADDR_BASE_DEFAULT = 1024;
  localparam int unsigned SRAM_DW           = 16;

endpackage

// File: rtl/sram_responder_if.sv
// Request/response bus between the MEM stage (master) and the SRAM responder (slave).
interface sram_responder_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready;

  modport master (
    output rd_en,
    output wr_en,
    output address,
    output wr_data,
    input  rd_data,
    input  ready
  );

  modport slave (
    input  rd_en,
    input  wr_en,
    input  address,
    input  wr_data,
    output rd_data,
    output ready
  );

endinterface

// File: rtl/sram_responder.sv
// Splits each 32-bit MEM request into two 16-bit async SRAM phases and holds ready low meanwhile.
module sram_responder
  import arm_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_responder_if.slave    bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned WidxW = SRAM_AW - 1;
  localparam logic [3:0]  LastCnt = 4'(WAIT_CYCLES - 1);

  mem_state_t       state_q;
  logic [3:0]       cnt_q;
  logic             wr_q;
  logic [WidxW-1:0] widx_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rd_data_q;

  logic             req;
  logic [31:0]      offset;
  logic [WidxW-1:0] widx_in;
  logic             last;
  logic [3:0]       cnt_inc;

  assign req     = bus.rd_en | bus.wr_en;
  assign offset  = bus.address - 32'(ADDR_BASE);
  // Word index wraps silently to the SRAM size; byte offset bits are ignored.
  assign widx_in = offset[WidxW+1:2];
  assign last    = (cnt_q == LastCnt);
  assign cnt_inc = cnt_q + 4'd1;

  logic unused_offset;
  assign unused_offset = ^{offset[31:WidxW+2], offset[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      widx_q      <= '0;
      wdata_q     <= 32'd0;
      rd_data_q   <= 32'd0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            // A simultaneous read+write is treated as a write.
            state_q    <= LO;
            cnt_q      <= 4'd0;
            wr_q       <= bus.wr_en;
            widx_q     <= widx_in;
            wdata_q    <= bus.wr_data;
            sram_addr  <= {widx_in, 1'b0};
            sram_dq_oe <= bus.wr_en;
            sram_we_n  <= ~bus.wr_en;
            sram_oe_n  <= bus.wr_en;
            if (bus.wr_en) begin
              sram_dq_out <= bus.wr_data[15:0];
            end
          end
        end
        LO, HI: begin
          if (last) begin
            cnt_q <= 4'd0;
            if (!wr_q) begin
              if (state_q == LO) begin
                rd_data_q[15:0] <= sram_dq_in;
              end else begin
                rd_data_q[31:16] <= sram_dq_in;
              end
            end
            if (state_q == LO) begin
              state_q   <= HI;
              sram_addr <= {widx_q, 1'b1};
              sram_we_n <= ~wr_q;
              if (wr_q) begin
                sram_dq_out <= wdata_q[31:16];
              end
            end else begin
              state_q    <= DONE;
              sram_we_n  <= 1'b1;
              sram_oe_n  <= 1'b1;
              sram_dq_oe <= 1'b0;
            end
          end else begin
            cnt_q     <= cnt_inc;
            // Last cycle of a write phase is recovery: we_n high, addr/data stable.
            sram_we_n <= ~wr_q | (cnt_inc == LastCnt);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.ready   = (state_q == DONE) | ((state_q == IDLE) & ~req);

endmodule

// File: tb/tb_sram_responder.sv
// Bench: sram_responder against a behavioural async SRAM, with a scoreboard for read data.
module tb_sram_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_responder_if bus0 ();
  sram_responder_if bus1 ();

  logic [17:0] a0;
  logic [15:0] dqo0, dqi0;
  logic        oe0, we0n, oe0n;
  logic [9:0]  a1;
  logic [15:0] dqo1, dqi1;
  logic        oe1, we1n, oe1n;

  sram_responder #(.WAIT_CYCLES(2), .ADDR_BASE(1024), .SRAM_AW(18)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .sram_addr(a0), .sram_dq_out(dqo0), .sram_dq_oe(oe0), .sram_dq_in(dqi0),
    .sram_we_n(we0n), .sram_oe_n(oe0n)
  );

  sram_responder #(.WAIT_CYCLES(3), .ADDR_BASE(1024), .SRAM_AW(10)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .sram_addr(a1), .sram_dq_out(dqo1), .sram_dq_oe(oe1), .sram_dq_in(dqi1),
    .sram_we_n(we1n), .sram_oe_n(oe1n)
  );

  // sram_model: level-sensitive write while we_n is low, output driven only while oe_n is low
  logic [15:0] mem0 [0:(1<<18)-1];
  logic [15:0] mem1 [0:(1<<10)-1];
  always @(we0n or a0 or dqo0 or oe0) if (!we0n && oe0) mem0[a0] = dqo0;
  always @(we1n or a1 or dqo1 or oe1) if (!we1n && oe1) mem1[a1] = dqo1;
  assign dqi0 = (!oe0n && we0n) ? mem0[a0] : 16'hFFFF;
  assign dqi1 = (!oe1n && we1n) ? mem1[a1] : 16'hFFFF;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;
  int          low_cnt, we_lo, we_hi;

  task automatic access0(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
    logic [31:0] off;
    logic [31:0] exp;
    int          widx;
    off  = addr - 32'd1024;
    widx = int'(off[18:2]);
    bus0.rd_en = rd; bus0.wr_en = wr; bus0.address = addr; bus0.wr_data = data;
    if (wr) ref_mem[widx] = data;
    else if (rd) exp_q.push_back(ref_mem[widx]);
    low_cnt = 0; we_lo = 0; we_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus0.ready) break;
      low_cnt++;
      if (!we0n) begin
        if (a0[0]) we_hi++;
        else we_lo++;
      end
    end
    checks++;
    if (bus0.ready !== 1'b1) begin
      failures++;
      $display("FAIL access_timeout addr=%h got ready=%b exp=1", addr, bus0.ready);
    end
    if (rd && !wr) begin
      exp = exp_q.pop_front();
      last_rd = exp;
      checks++;
      if (bus0.rd_data !== exp) begin
        failures++;
        $display("FAIL read_data addr=%h got=%h exp=%h", addr, bus0.rd_data, exp);
      end
    end
    @(posedge clk); #1;
    bus0.rd_en = 1'b0; bus0.wr_en = 1'b0;
  endtask

  task automatic access1(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp);
    bus1.rd_en = rd; bus1.wr_en = wr; bus1.address = addr; bus1.wr_data = data;
    low_cnt = 0; we_lo = 0; we_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus1.ready) break;
      low_cnt++;
      if (!we1n) begin
        if (a1[0]) we_hi++;
        else we_lo++;
      end
    end
    if (rd) begin
      checks++;
      if (bus1.rd_data !== exp) begin
        failures++;
        $display("FAIL w3_read_data got=%h exp=%h", bus1.rd_data, exp);
      end
    end
    @(posedge clk); #1;
    bus1.rd_en = 1'b0; bus1.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [69:0] got;
    #12;
    got = {bus0.ready, we0n, oe0n, oe0, a0, dqo0, bus0.rd_data};
    checks++;
    if (got !== {1'b1, 1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_state got=%h", got);
    end
    bus0.rd_en = 1'b1; #1;
    checks++;
    if (bus0.ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_req got=%b exp=0", bus0.ready);
    end
    bus0.rd_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    access0(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    checks++;
    if (low_cnt != 5) begin failures++; $display("FAIL write_ready_low got=%0d exp=5", low_cnt); end
    checks++;
    if (we_lo != 1 || we_hi != 1) begin
      failures++;
      $display("FAIL write_we_pulse got lo=%0d hi=%0d exp lo=1 hi=1", we_lo, we_hi);
    end
    checks++;
    if ({mem0[1], mem0[0]} !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_halfwords got=%h exp=deadbeef", {mem0[1], mem0[0]});
    end
  endtask

  task automatic test_read();
    access0(1'b1, 1'b0, 32'd1024, 32'd0);
    checks++;
    if (low_cnt != 5) begin failures++; $display("FAIL read_ready_low got=%0d exp=5", low_cnt); end
    access0(1'b0, 1'b1, 32'd1028, 32'h11112222);
    checks++;
    if (bus0.rd_data !== last_rd) begin
      failures++;
      $display("FAIL rd_data_hold got=%h exp=%h", bus0.rd_data, last_rd);
    end
  endtask

  task automatic test_rd_wr_both();
    access0(1'b1, 1'b1, 32'd1032, 32'h12345678);
    checks++;
    if ({mem0[5], mem0[4]} !== 32'h12345678 || bus0.rd_data !== last_rd) begin
      failures++;
      $display("FAIL rdwr_write_only got mem=%h rd=%h exp mem=12345678 rd=%h",
               {mem0[5], mem0[4]}, bus0.rd_data, last_rd);
    end
    access0(1'b1, 1'b0, 32'd1032, 32'd0);
  endtask

  task automatic test_mid_change();
    access0(1'b0, 1'b1, 32'd2000, 32'h5A5AA5A5);
    ref_mem[4] = 32'hCAFEF00D;
    bus0.wr_en = 1'b1; bus0.address = 32'd1040; bus0.wr_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus0.wr_en = 1'b0; bus0.address = 32'd2000; bus0.wr_data = 32'd0;
    low_cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus0.ready) break;
      low_cnt++;
    end
    checks++;
    if (low_cnt != 5) begin failures++; $display("FAIL mid_ready_low got=%0d exp=5", low_cnt); end
    @(posedge clk); #1;
    checks++;
    if ({mem0[9], mem0[8]} !== 32'hCAFEF00D || {mem0[489], mem0[488]} !== 32'h5A5AA5A5) begin
      failures++;
      $display("FAIL mid_change got latched=%h other=%h exp latched=cafef00d other=5a5aa5a5",
               {mem0[9], mem0[8]}, {mem0[489], mem0[488]});
    end
    access0(1'b1, 1'b0, 32'd1040, 32'd0);
  endtask

  task automatic test_back_to_back();
    access0(1'b0, 1'b1, 32'd1036, 32'h0BADC0DE);
    access0(1'b1, 1'b0, 32'd1036, 32'd0);
    checks++;
    if (low_cnt != 5) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=5", low_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [69:0] got;
    bus0.rd_en = 1'b1; bus0.address = 32'd1024;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (oe0n !== 1'b0 || a0 !== 18'd1) begin
      failures++;
      $display("FAIL rstmid_in_hi got oe_n=%b addr=%h exp oe_n=0 addr=1", oe0n, a0);
    end
    rst = 1'b0; #1;
    got = {bus0.ready, we0n, oe0n, oe0, a0, dqo0, bus0.rd_data};
    checks++;
    if (got !== {1'b0, 1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 32'd0}) begin
      failures++;
      $display("FAIL rstmid_state got=%h", got);
    end
    bus0.rd_en = 1'b0; #1;
    checks++;
    if (bus0.ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_ready got=%b exp=1", bus0.ready);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    access0(1'b1, 1'b0, 32'd1024, 32'd0);
  endtask

  task automatic test_wait3();
    access1(1'b0, 1'b1, 32'd1024, 32'hA1B2C3D4, 32'd0);
    checks++;
    if (low_cnt != 7) begin failures++; $display("FAIL w3_ready_low got=%0d exp=7", low_cnt); end
    checks++;
    if (we_lo != 2 || we_hi != 2) begin
      failures++;
      $display("FAIL w3_we_pulse got lo=%0d hi=%0d exp lo=2 hi=2", we_lo, we_hi);
    end
    access1(1'b1, 1'b0, 32'd1024, 32'd0, 32'hA1B2C3D4);
    checks++;
    if (low_cnt != 7) begin failures++; $display("FAIL w3_read_low got=%0d exp=7", low_cnt); end
  endtask

  initial begin
    bus0.rd_en = 1'b0; bus0.wr_en = 1'b0; bus0.address = 32'd0; bus0.wr_data = 32'd0;
    bus1.rd_en = 1'b0; bus1.wr_en = 1'b0; bus1.address = 32'd0; bus1.wr_data = 32'd0;
    test_reset();
    test_write();
    test_read();
    test_rd_wr_both();
    test_mid_change();
    test_back_to_back();
    test_reset_mid();
    test_wait3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
